// File: rtl/video_out_stage.sv
// Final video output stage: re-aligns sync/visible with the pixel pipeline,
// blanks colour outside the visible area, registers every off-chip pin and
// turns the start of vblank into a pulse, a frame count and a sticky CPU IRQ.
//
// Handshake: there is no valid/ready pair on this block. Timing inputs are
// consumed every clock. The IRQ is level-held: it is raised by a vblank event
// and stays raised until irq_ack_i is seen high on a clock edge with no
// simultaneous vblank event. The IRQ state register is visible on
// vblank_irq_o (IDLE = 0, PENDING = 1).
module video_out_stage #(
    parameter int PIPE_DEPTH = 2,
    parameter int COLOR_W    = 6,
    parameter int FRAME_W    = 16
) (
    input  logic               clk_12_5875,
    input  logic               rst_n,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               visible_i,
    input  logic               writable_i,
    input  logic [COLOR_W-1:0] color_i,
    input  logic               irq_ack_i,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [COLOR_W-1:0] color_o,
    output logic               vblank_start_o,
    output logic               vblank_irq_o,
    output logic               irq_overrun_o,
    output logic [FRAME_W-1:0] frame_count_o
);

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic visible;
    } timing_t;

    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_PENDING = 1'b1
    } irq_state_t;

    // Syncs idle high, nothing visible while the line is flushed.
    localparam timing_t TIMING_IDLE = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0};

    timing_t              pipe_q [PIPE_DEPTH];
    timing_t              tap;
    logic                 hsync_q;
    logic                 vsync_q;
    logic [COLOR_W-1:0]   color_q;
    logic [COLOR_W-1:0]   color_d;
    logic                 writable_q;
    logic                 vblank_evt;
    logic                 vblank_start_q;
    irq_state_t           irq_state_q;
    logic                 overrun_q;
    logic [FRAME_W-1:0]   frame_q;
    logic [FRAME_W-1:0]   frame_d;

    assign tap        = pipe_q[PIPE_DEPTH-1];
    // Undelayed writable so the IRQ reaches the CPU as early as possible.
    assign vblank_evt = writable_i & ~writable_q;

    // Next-state values for the colour pin and the frame counter.
    always_comb begin
        color_d = tap.visible ? color_i : '0;
        frame_d = vblank_evt ? frame_q + FRAME_W'(1) : frame_q;
    end

    // Timing delay line: stage 0 captures the generator, the last stage is the tap.
    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= TIMING_IDLE;
        end else begin
            pipe_q[0] <= '{hsync: hsync_i, vsync: vsync_i, visible: visible_i};
            for (int i = 1; i < PIPE_DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Off-chip pin registers: syncs from the tap, colour blanked by the tap's visible.
    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            color_q <= '0;
        end else begin
            hsync_q <= tap.hsync;
            vsync_q <= tap.vsync;
            color_q <= color_d;
        end
    end

    // Vblank edge detect; writable resets high so a release mid-vblank is silent.
    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            writable_q     <= 1'b1;
            vblank_start_q <= 1'b0;
            frame_q        <= '0;
        end else begin
            writable_q     <= writable_i;
            vblank_start_q <= vblank_evt;
            frame_q        <= frame_d;
        end
    end

    // IRQ FSM: a new vblank always wins over an ack arriving on the same edge.
    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            irq_state_q <= IRQ_IDLE;
            overrun_q   <= 1'b0;
        end else begin
            case (irq_state_q)
                IRQ_IDLE: begin
                    if (vblank_evt) begin
                        irq_state_q <= IRQ_PENDING;
                        overrun_q   <= 1'b0;
                    end
                end
                IRQ_PENDING: begin
                    if (vblank_evt) begin
                        irq_state_q <= IRQ_PENDING;
                        overrun_q   <= ~irq_ack_i;
                    end else if (irq_ack_i) begin
                        irq_state_q <= IRQ_IDLE;
                        overrun_q   <= 1'b0;
                    end
                end
                default: begin
                    irq_state_q <= IRQ_IDLE;
                    overrun_q   <= 1'b0;
                end
            endcase
        end
    end

    assign hsync_o        = hsync_q;
    assign vsync_o        = vsync_q;
    assign color_o        = color_q;
    assign vblank_start_o = vblank_start_q;
    assign vblank_irq_o   = (irq_state_q == IRQ_PENDING);
    assign irq_overrun_o  = overrun_q;
    assign frame_count_o  = frame_q;

endmodule
